// File: rtl/weight_pkg.sv
// Shared types and the saturating gradient-descent step used by the weight
// bank and the other gradient-descent units.
package weight_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CLEAR = 2'd1,
        UPD   = 2'd2
    } wb_state_t;

    // Widest weight the shared helper supports; callers sign-extend into it.
    localparam int GDO_MAX_W = 32;

    // Returns {sat, result}: result = w - (g >>> shift), clamped to a signed
    // 'width'-bit range and sign-extended back to GDO_MAX_W bits.
    function automatic logic [GDO_MAX_W:0] gdo_sat_sub(
        input logic signed [GDO_MAX_W-1:0] w,
        input logic signed [GDO_MAX_W-1:0] g,
        input logic        [3:0]           shift,
        input int                          width
    );
        logic signed [GDO_MAX_W-1:0] step;
        logic signed [GDO_MAX_W:0]   diff;
        logic signed [GDO_MAX_W:0]   hi;
        logic signed [GDO_MAX_W:0]   lo;
        logic signed [GDO_MAX_W:0]   one;
        logic                        sat;
        one  = 1;
        step = g >>> shift;
        diff = {w[GDO_MAX_W-1], w} - {step[GDO_MAX_W-1], step};
        hi   = (one <<< (width - 1)) - one;
        lo   = -(one <<< (width - 1));
        sat  = 1'b0;
        if (diff > hi) begin
            diff = hi;
            sat  = 1'b1;
        end else if (diff < lo) begin
            diff = lo;
            sat  = 1'b1;
        end
        return {sat, diff[GDO_MAX_W-1:0]};
    endfunction

endpackage

// File: rtl/weight_row_update.sv
// Combinational gradient-descent step for one weight row: every column is
// shifted, subtracted and saturated independently.
module weight_row_update
    import weight_pkg::*;
#(
    parameter int DATA_SIZE = 16,
    parameter int COLS      = 3
) (
    input  logic [DATA_SIZE*COLS-1:0] row_in,
    input  logic [DATA_SIZE*COLS-1:0] grad,
    input  logic [3:0]                shift,
    output logic [DATA_SIZE*COLS-1:0] row_out,
    output logic                      sat
);

    logic [COLS-1:0] col_sat;

    always_comb begin
        logic signed [DATA_SIZE-1:0]   w_n;
        logic signed [DATA_SIZE-1:0]   g_n;
        logic signed [GDO_MAX_W-1:0]   w_x;
        logic signed [GDO_MAX_W-1:0]   g_x;
        logic [GDO_MAX_W:0]            res;
        logic [GDO_MAX_W-DATA_SIZE:0]  ext;
        w_n     = '0;
        g_n     = '0;
        w_x     = '0;
        g_x     = '0;
        res     = '0;
        ext     = '0;
        row_out = '0;
        col_sat = '0;
        for (int c = 0; c < COLS; c++) begin
            w_n = row_in[c*DATA_SIZE +: DATA_SIZE];
            g_n = grad[c*DATA_SIZE +: DATA_SIZE];
            w_x = w_n;
            g_x = g_n;
            res = gdo_sat_sub(w_x, g_x, shift, DATA_SIZE);
            // Upper bits must be a clean sign extension of the clamped value;
            // anything else is treated as an overflow as well.
            ext = res[GDO_MAX_W-1:DATA_SIZE-1];
            col_sat[c] = res[GDO_MAX_W] | ((ext != '0) && (ext != '1));
            row_out[c*DATA_SIZE +: DATA_SIZE] = res[DATA_SIZE-1:0];
        end
    end

    assign sat = |col_sat;

endmodule

// File: rtl/weight_bank.sv
// Weight memory for the training data path: registered row reads, host row
// writes, handshaked gradient-descent updates and a row-per-cycle clear sweep.
module weight_bank
    import weight_pkg::*;
#(
    parameter  int DATA_SIZE = 16,
    parameter  int FRAC_BITS = 8,
    parameter  int COLS      = 3,
    parameter  int ROWS      = 3,
    parameter  int LAYERS    = 5,
    localparam int LW        = (LAYERS > 1) ? $clog2(LAYERS) : 1,
    localparam int RW        = (ROWS > 1) ? $clog2(ROWS) : 1
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      rd_en,
    input  logic [LW-1:0]             rd_layer,
    input  logic [RW-1:0]             rd_row,
    output logic [DATA_SIZE*COLS-1:0] rd_data,
    output logic                      rd_valid,
    input  logic                      wr_en,
    input  logic [LW-1:0]             wr_layer,
    input  logic [RW-1:0]             wr_row,
    input  logic [DATA_SIZE*COLS-1:0] wr_data,
    input  logic                      upd_valid,
    output logic                      upd_ready,
    input  logic [LW-1:0]             upd_layer,
    input  logic [RW-1:0]             upd_row,
    input  logic [DATA_SIZE*COLS-1:0] upd_grad,
    input  logic [3:0]                lr_shift,
    input  logic                      clr_start,
    output logic                      busy,
    output logic                      sat_flag,
    output logic                      idx_err
);

    localparam int NR = LAYERS * ROWS;
    localparam int CW = (NR > 1) ? $clog2(NR) : 1;
    localparam int DW = DATA_SIZE * COLS;
    localparam logic [CW-1:0] LAST = CW'(NR - 1);

    if (FRAC_BITS >= DATA_SIZE || DATA_SIZE > GDO_MAX_W) begin : g_bad_params
        $error("weight_bank: unsupported DATA_SIZE/FRAC_BITS combination");
    end

    wb_state_t      state, state_nxt;
    logic [CW-1:0]  cnt, cnt_nxt;
    logic [DW-1:0]  mem [NR];
    logic [CW-1:0]  upd_idx;
    logic [DW-1:0]  upd_grad_q;
    logic [3:0]     upd_shift_q;
    logic [DW-1:0]  row_cur;
    logic [DW-1:0]  row_new;
    logic           row_sat;
    logic           upd_acc, upd_commit;
    logic           rd_ok, wr_ok, upd_ok, wr_act;

    function automatic logic in_range(input logic [LW-1:0] l, input logic [RW-1:0] r);
        return (int'(l) < LAYERS) && (int'(r) < ROWS);
    endfunction

    function automatic logic [CW-1:0] flat(input logic [LW-1:0] l, input logic [RW-1:0] r);
        return CW'(int'(l) * ROWS + int'(r));
    endfunction

    assign rd_ok  = in_range(rd_layer, rd_row);
    assign wr_ok  = in_range(wr_layer, wr_row);
    assign upd_ok = in_range(upd_layer, upd_row);
    assign wr_act = wr_en && (state != CLEAR);
    assign busy   = (state != IDLE);

    always_comb begin
        state_nxt  = state;
        cnt_nxt    = cnt;
        upd_ready  = 1'b0;
        upd_acc    = 1'b0;
        upd_commit = 1'b0;
        case (state)
            IDLE: begin
                upd_ready = !wr_en && !clr_start;
                upd_acc   = upd_valid && upd_ready;
                if (clr_start) begin
                    state_nxt = CLEAR;
                    cnt_nxt   = '0;
                end else if (upd_acc && upd_ok) begin
                    state_nxt = UPD;
                end
            end
            CLEAR: begin
                if (clr_start) begin
                    cnt_nxt = '0;
                end else if (cnt == LAST) begin
                    state_nxt = IDLE;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            UPD: begin
                if (clr_start) begin
                    state_nxt = CLEAR;
                    cnt_nxt   = '0;
                end else begin
                    upd_commit = 1'b1;
                    state_nxt  = IDLE;
                end
            end
            default: begin
                state_nxt = CLEAR;
                cnt_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= CLEAR;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (upd_acc) begin
            upd_idx     <= flat(upd_layer, upd_row);
            upd_grad_q  <= upd_grad;
            upd_shift_q <= lr_shift;
        end
    end

    assign row_cur = mem[upd_idx];

    weight_row_update #(
        .DATA_SIZE (DATA_SIZE),
        .COLS      (COLS)
    ) u_row_update (
        .row_in  (row_cur),
        .grad    (upd_grad_q),
        .shift   (upd_shift_q),
        .row_out (row_new),
        .sat     (row_sat)
    );

    // The update write is last so it wins over a host write to the same row.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            if (state == CLEAR) mem[cnt] <= '0;
            if (wr_act && wr_ok) mem[flat(wr_layer, wr_row)] <= wr_data;
            if (upd_commit) mem[upd_idx] <= row_new;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_data  <= '0;
            rd_valid <= 1'b0;
            sat_flag <= 1'b0;
            idx_err  <= 1'b0;
        end else begin
            rd_valid <= rd_en;
            if (rd_en) rd_data <= rd_ok ? mem[flat(rd_layer, rd_row)] : '0;
            if (clr_start) begin
                sat_flag <= 1'b0;
                idx_err  <= 1'b0;
            end else begin
                if (upd_commit && row_sat) sat_flag <= 1'b1;
                if ((rd_en && !rd_ok) || (wr_act && !wr_ok) || (upd_acc && !upd_ok))
                    idx_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_weight_bank.sv
// Randomized and directed bench for weight_bank: a behavioural row model feeds a
// read scoreboard drained by an independent monitor.
module tb_weight_bank;

    localparam int DATA_SIZE = 16;
    localparam int COLS      = 3;
    localparam int ROWS      = 3;
    localparam int LAYERS    = 5;
    localparam int LW        = 3;
    localparam int RW        = 2;
    localparam int NR        = LAYERS * ROWS;
    localparam int DW        = DATA_SIZE * COLS;
    localparam int WMAX      = 32767;
    localparam int WMIN      = -32768;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          rd_en;
    logic [LW-1:0] rd_layer;
    logic [RW-1:0] rd_row;
    logic [DW-1:0] rd_data;
    logic          rd_valid;
    logic          wr_en;
    logic [LW-1:0] wr_layer;
    logic [RW-1:0] wr_row;
    logic [DW-1:0] wr_data;
    logic          upd_valid;
    logic          upd_ready;
    logic [LW-1:0] upd_layer;
    logic [RW-1:0] upd_row;
    logic [DW-1:0] upd_grad;
    logic [3:0]    lr_shift;
    logic          clr_start;
    logic          busy;
    logic          sat_flag;
    logic          idx_err;

    always #5 clk = ~clk;

    weight_bank #(
        .DATA_SIZE (DATA_SIZE),
        .FRAC_BITS (8),
        .COLS      (COLS),
        .ROWS      (ROWS),
        .LAYERS    (LAYERS)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .rd_en     (rd_en),
        .rd_layer  (rd_layer),
        .rd_row    (rd_row),
        .rd_data   (rd_data),
        .rd_valid  (rd_valid),
        .wr_en     (wr_en),
        .wr_layer  (wr_layer),
        .wr_row    (wr_row),
        .wr_data   (wr_data),
        .upd_valid (upd_valid),
        .upd_ready (upd_ready),
        .upd_layer (upd_layer),
        .upd_row   (upd_row),
        .upd_grad  (upd_grad),
        .lr_shift  (lr_shift),
        .clr_start (clr_start),
        .busy      (busy),
        .sat_flag  (sat_flag),
        .idx_err   (idx_err)
    );

    int total = 0;
    int bad   = 0;
    logic [DW-1:0] exp_q[$];

    typedef enum int {PH_IDLE, PH_CLEAR, PH_UPD} phase_t;
    logic [DW-1:0] model [NR];
    phase_t        m_phase;
    int            m_cnt;
    bit            m_sat;
    bit            m_err;
    int            p_idx;
    logic [DW-1:0] p_grad;
    int            p_shift;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int col(input logic [DW-1:0] row, input int c);
        logic signed [DATA_SIZE-1:0] v;
        v = row[(COLS-1-c)*DATA_SIZE +: DATA_SIZE];
        return int'(v);
    endfunction

    function automatic int floor_pow2(input int g, input int sh);
        int d;
        int q;
        d = 1 << sh;
        q = g / d;
        if ((g % d) != 0 && g < 0) q = q - 1;
        return q;
    endfunction

    function automatic logic [DW-1:0] ref_update(input logic [DW-1:0] w, input logic [DW-1:0] g,
                                                 input int sh, output bit s);
        logic [DW-1:0] r;
        int n;
        r = '0;
        s = 1'b0;
        for (int c = 0; c < COLS; c++) begin
            n = col(w, c) - floor_pow2(col(g, c), sh);
            if (n > WMAX) begin n = WMAX; s = 1'b1; end
            if (n < WMIN) begin n = WMIN; s = 1'b1; end
            r[(COLS-1-c)*DATA_SIZE +: DATA_SIZE] = 16'(n);
        end
        return r;
    endfunction

    function automatic bit in_rng(input int l, input int r);
        return (l < LAYERS) && (r < ROWS);
    endfunction

    task automatic quiet();
        rd_en = 0; rd_layer = '0; rd_row = '0;
        wr_en = 0; wr_layer = '0; wr_row = '0; wr_data = '0;
        upd_valid = 0; upd_layer = '0; upd_row = '0; upd_grad = '0; lr_shift = '0;
        clr_start = 0;
    endtask

    task automatic host_write();
        if (wr_en) begin
            if (in_rng(int'(wr_layer), int'(wr_row))) model[int'(wr_layer)*ROWS + int'(wr_row)] = wr_data;
            else m_err = 1'b1;
        end
    endtask

    // One clock: check status against the model, predict this edge, advance.
    task automatic tick();
        bit            push;
        logic [DW-1:0] rexp;
        logic [DW-1:0] ures;
        bit            us;
        #1;
        check("busy", 64'(busy), 64'(m_phase != PH_IDLE));
        check("upd_ready", 64'(upd_ready), 64'(m_phase == PH_IDLE && !wr_en && !clr_start));
        check("sat_flag", 64'(sat_flag), 64'(m_sat));
        check("idx_err", 64'(idx_err), 64'(m_err));
        push = rd_en;
        rexp = '0;
        if (rd_en) begin
            if (in_rng(int'(rd_layer), int'(rd_row))) rexp = model[int'(rd_layer)*ROWS + int'(rd_row)];
            else m_err = 1'b1;
        end
        us = 1'b0;
        ures = (m_phase == PH_UPD) ? ref_update(model[p_idx], p_grad, p_shift, us) : '0;
        case (m_phase)
            PH_CLEAR: begin
                model[m_cnt] = '0;
                if (clr_start) m_cnt = 0;
                else if (m_cnt == NR - 1) m_phase = PH_IDLE;
                else m_cnt++;
            end
            PH_IDLE: begin
                host_write();
                if (clr_start) begin
                    m_phase = PH_CLEAR;
                    m_cnt   = 0;
                end else if (upd_valid && !wr_en) begin
                    if (in_rng(int'(upd_layer), int'(upd_row))) begin
                        p_idx   = int'(upd_layer)*ROWS + int'(upd_row);
                        p_grad  = upd_grad;
                        p_shift = int'(lr_shift);
                        m_phase = PH_UPD;
                    end else begin
                        m_err = 1'b1;
                    end
                end
            end
            PH_UPD: begin
                host_write();
                if (clr_start) begin
                    m_phase = PH_CLEAR;
                    m_cnt   = 0;
                end else begin
                    model[p_idx] = ures;
                    if (us) m_sat = 1'b1;
                    m_phase = PH_IDLE;
                end
            end
            default: ;
        endcase
        if (clr_start) begin
            m_sat = 1'b0;
            m_err = 1'b0;
        end
        @(posedge clk);
        if (push) exp_q.push_back(rexp);
        #1;
    endtask

    task automatic do_write(input int l, input int r, input logic [DW-1:0] d);
        quiet(); wr_en = 1; wr_layer = LW'(l); wr_row = RW'(r); wr_data = d;
        tick();
    endtask

    task automatic do_read(input int l, input int r);
        quiet(); rd_en = 1; rd_layer = LW'(l); rd_row = RW'(r);
        tick();
    endtask

    task automatic do_update(input int l, input int r, input logic [DW-1:0] g, input int sh);
        quiet(); upd_valid = 1; upd_layer = LW'(l); upd_row = RW'(r); upd_grad = g; lr_shift = 4'(sh);
        tick();
    endtask

    task automatic expect_read(input string name, input logic [DW-1:0] exp);
        @(negedge clk);
        check(name, 64'(rd_data), 64'(exp));
        check({name, "_valid"}, 64'(rd_valid), 64'(1));
    endtask

    task automatic read_all();
        for (int l = 0; l < LAYERS; l++)
            for (int r = 0; r < ROWS; r++)
                do_read(l, r);
        quiet();
        tick();
    endtask

    function automatic logic [DATA_SIZE-1:0] rnd_word();
        case ($urandom_range(0, 3))
            0: return 16'h7FFF - 16'($urandom_range(0, 255));
            1: return 16'h8000 + 16'($urandom_range(0, 255));
            default: return 16'($urandom());
        endcase
    endfunction

    function automatic logic [DW-1:0] rnd_row();
        return {rnd_word(), rnd_word(), rnd_word()};
    endfunction

    function automatic int rnd_layer();
        return ($urandom_range(0, 11) == 0) ? int'($urandom_range(LAYERS, 7)) : int'($urandom_range(0, LAYERS-1));
    endfunction

    function automatic int rnd_row_idx();
        return ($urandom_range(0, 11) == 0) ? 3 : int'($urandom_range(0, ROWS-1));
    endfunction

    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            check("rd_valid_timing", 64'(rd_valid), 64'(exp_q.size() != 0));
            if (rd_valid && exp_q.size() != 0) check("rd_data", 64'(rd_data), 64'(exp_q.pop_front()));
            else if (exp_q.size() != 0) void'(exp_q.pop_front());
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        quiet();
        rst_n = 0;
        for (int i = 0; i < NR; i++) model[i] = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_rd_valid", 64'(rd_valid), 64'(0));
        check("rst_rd_data", 64'(rd_data), 64'(0));
        check("rst_upd_ready", 64'(upd_ready), 64'(0));
        check("rst_busy", 64'(busy), 64'(1));
        rst_n   = 1;
        m_phase = PH_CLEAR;
        m_cnt   = 0;
        m_sat   = 0;
        m_err   = 0;

        n = 0;
        while (busy && n < 40) begin
            tick();
            n++;
        end
        check("reset_busy_cycles", 64'(n), 64'(15));
        read_all();

        do_write(2, 1, {16'h0100, 16'hFF00, 16'h0080});
        do_read(2, 1);
        expect_read("wr_rd_l2r1", {16'h0100, 16'hFF00, 16'h0080});

        do_write(0, 0, {16'h0100, 16'h0100, 16'h0100});
        do_update(0, 0, {16'h0200, 16'h0200, 16'h0200}, 2);
        check("upd_cycle_ready", 64'(upd_ready), 64'(0));
        check("upd_cycle_busy", 64'(busy), 64'(1));
        quiet(); tick();
        do_read(0, 0);
        expect_read("upd_half", {16'h0080, 16'h0080, 16'h0080});

        do_write(1, 2, {16'h7F00, 16'h7F00, 16'h0000});
        do_update(1, 2, {16'h8000, 16'h0000, 16'h0000}, 0);
        quiet(); tick();
        do_read(1, 2);
        expect_read("sat_result", {16'h7FFF, 16'h7F00, 16'h0000});
        check("sat_flag_set", 64'(sat_flag), 64'(1));
        quiet(); repeat (3) tick();
        check("sat_flag_sticky", 64'(sat_flag), 64'(1));

        do_write(3, 0, {16'h0400, 16'h0400, 16'h0400});
        do_update(3, 0, {16'h0100, 16'h0100, 16'h0100}, 0);
        quiet();
        wr_en = 1; wr_layer = 3; wr_row = 0; wr_data = {16'h1111, 16'h2222, 16'h3333};
        rd_en = 1; rd_layer = 3; rd_row = 0;
        tick();
        expect_read("collide_old", {16'h0400, 16'h0400, 16'h0400});
        do_read(3, 0);
        expect_read("collide_upd_wins", {16'h0300, 16'h0300, 16'h0300});

        do_write(4, 2, {16'h0500, 16'h0500, 16'h0500});
        do_update(4, 2, {16'h0100, 16'h0100, 16'h0100}, 0);
        quiet(); clr_start = 1; tick();
        quiet();
        n = 0;
        while (busy && n < 40) begin
            tick();
            n++;
        end
        check("abort_sweep_cycles", 64'(n), 64'(15));
        check("abort_sat_cleared", 64'(sat_flag), 64'(0));
        do_read(4, 2);
        expect_read("abort_row_cleared", '0);

        do_write(2, 2, {16'h0A0A, 16'h0B0B, 16'h0C0C});
        do_update(5, 2, {16'h0100, 16'h0100, 16'h0100}, 0);
        check("idx_err_upd", 64'(idx_err), 64'(1));
        check("idx_err_no_upd", 64'(busy), 64'(0));
        do_read(0, 3);
        expect_read("oor_read_zero", '0);
        read_all();

        quiet(); clr_start = 1; tick();
        quiet();
        for (int k = 0; k < 500; k++) begin
            quiet();
            rd_en = 1'($urandom_range(0, 1));
            rd_layer = LW'(rnd_layer()); rd_row = RW'(rnd_row_idx());
            wr_en = ($urandom_range(0, 3) == 0);
            wr_layer = LW'(rnd_layer()); wr_row = RW'(rnd_row_idx()); wr_data = rnd_row();
            upd_valid = ($urandom_range(0, 1) == 0);
            upd_layer = LW'(rnd_layer()); upd_row = RW'(rnd_row_idx()); upd_grad = rnd_row();
            lr_shift = ($urandom_range(0, 1) == 0) ? 4'($urandom_range(0, 2)) : 4'($urandom_range(0, 15));
            clr_start = ($urandom_range(0, 79) == 0);
            tick();
        end

        quiet();
        n = 0;
        while (busy && n < 40) begin
            tick();
            n++;
        end
        read_all();
        quiet(); tick();
        check("scoreboard_drained", 64'(exp_q.size()), 64'(0));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
